// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchroniser, start-edge detect, mid-bit sampling, sticky rdy.
// Optional stop-bit checking on framing_err is enabled with `define UART_RX_FRAME_ERR_EN.
module uart_rx #(
    parameter int BAUD_CNT = 434,
    parameter int HALF_CNT = BAUD_CNT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       framing_err
);

    localparam logic [8:0] BAUD_LD = 9'(BAUD_CNT);
    localparam logic [8:0] HALF_LD = 9'(HALF_CNT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_nxt;
    logic        rx_meta, rx_sync, rx_prev;
    logic [8:0]  baud_cnt, baud_nxt;
    logic [3:0]  bit_cnt, bit_nxt;
    logic [7:0]  shift_reg, shift_nxt;
    logic        start_edge, baud_tick;
    logic        frame_start, commit;

    assign start_edge = rx_prev & ~rx_sync;
    // The sample point is the decrement that brings baud_cnt to zero.
    assign baud_tick  = (baud_cnt == 9'd1);

`ifdef UART_RX_FRAME_ERR_EN
    logic stop_bit, stop_nxt;
`endif

    always_comb begin
        state_nxt   = state;
        baud_nxt    = baud_cnt;
        bit_nxt     = bit_cnt;
        shift_nxt   = shift_reg;
        frame_start = 1'b0;
        commit      = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        stop_nxt    = stop_bit;
`endif
        case (state)
            IDLE: begin
                if (start_edge) begin
                    baud_nxt    = HALF_LD;
                    state_nxt   = START;
                    frame_start = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (rx_sync) begin
                        baud_nxt  = 9'd0;
                        state_nxt = IDLE;
                    end else begin
                        baud_nxt  = BAUD_LD;
                        bit_nxt   = 4'd0;
                        state_nxt = DATA;
                    end
                end else begin
                    baud_nxt = baud_cnt - 9'd1;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_nxt = {rx_sync, shift_reg[7:1]};
                    baud_nxt  = BAUD_LD;
                    bit_nxt   = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7)
                        state_nxt = STOP;
                end else begin
                    baud_nxt = baud_cnt - 9'd1;
                end
            end
            STOP: begin
                // Commit one cycle after the stop sample, still mid stop bit,
                // so a back-to-back start edge is not missed.
                if (baud_cnt == 9'd0) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    baud_nxt = baud_cnt - 9'd1;
`ifdef UART_RX_FRAME_ERR_EN
                    if (baud_tick)
                        stop_nxt = rx_sync;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= IDLE;
            baud_cnt  <= 9'd0;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'h00;
            rx_data   <= 8'h00;
            rdy       <= 1'b0;
        end else begin
            rx_meta   <= RX;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
            if (commit)
                rx_data <= shift_reg;
            if (commit)
                rdy <= 1'b1;
            else if (frame_start || clr_rdy)
                rdy <= 1'b0;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stop_bit    <= 1'b1;
            framing_err <= 1'b0;
        end else begin
            stop_bit <= stop_nxt;
            if (commit)
                framing_err <= ~stop_bit;
            else if (frame_start || clr_rdy)
                framing_err <= 1'b0;
        end
    end
`else
    assign framing_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised by the bench, expected bytes and
// completion cycles are queued at send time and checked by an independent monitor.
module tb_uart_rx;

    localparam int BAUD = 434;
    localparam int HALF = BAUD / 2;
    // Drive-to-completion latency: 3 flop stages before the edge is seen, mid-start
    // sample, 9 further bit periods to the stop sample, then one cycle to commit.
    localparam int LAT  = 3 + HALF + 9 * BAUD + 1;
`ifdef UART_RX_FRAME_ERR_EN
    localparam bit FERR_EN = 1'b1;
`else
    localparam bit FERR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        int         cyc;
    } exp_t;

    logic       clk, rst, RX, clr_rdy;
    logic [7:0] rx_data;
    logic       rdy, framing_err;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    logic rdy_q = 1'b0;
    exp_t me;

    uart_rx dut (
        .clk(clk), .rst(rst), .RX(RX), .clr_rdy(clr_rdy),
        .rx_data(rx_data), .rdy(rdy), .framing_err(framing_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; drives one 10-bit frame, LSB first.
    task automatic send_frame(input logic [7:0] d, input logic stop_val);
        exp_t e;
        e.data = d;
        e.ferr = FERR_EN & ~stop_val;
        e.cyc  = cyc + LAT;
        sb.push_back(e);
        RX = 1'b0;
        idle(BAUD);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            idle(BAUD);
        end
        RX = stop_val;
        idle(BAUD);
        RX = 1'b1;
    endtask

    // Monitor: every rdy rising edge must match the head of the scoreboard.
    initial forever begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (rdy === 1'b1 && rdy_q !== 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rdy", {31'b0, rdy}, 32'd0);
                end else begin
                    me = sb.pop_front();
                    chk("rx_data", {24'b0, rx_data}, {24'b0, me.data});
                    chk("framing_err", {31'b0, framing_err}, {31'b0, me.ferr});
                    chk("rdy_cycle", cyc, me.cyc);
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                me = sb.pop_front();
                chk("rdy_missing", {31'b0, rdy}, 32'd1);
            end
            rdy_q = rdy;
        end
    end

    initial begin
        logic [7:0] d;
        logic [7:0] ab;
        int         gap;
        rst = 1'b1; RX = 1'b1; clr_rdy = 1'b0;
        idle(3);
        chk("reset_rdy", {31'b0, rdy}, 32'd0);
        chk("reset_data", {24'b0, rx_data}, 32'd0);
        chk("reset_ferr", {31'b0, framing_err}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(10);

        send_frame(8'h3A, 1'b1);
        idle(10);

        // back-to-back: rdy stays up until the second start edge clears it
        send_frame(8'hA5, 1'b1);
        fork
            send_frame(8'h5A, 1'b1);
            begin
                idle(2);
                chk("b2b_rdy_held", {31'b0, rdy}, 32'd1);
                idle(1);
                chk("b2b_rdy_cleared", {31'b0, rdy}, 32'd0);
            end
        join
        idle(10);

        // glitch shorter than half a bit is a false start
        RX = 1'b0;
        idle(100);
        RX = 1'b1;
        idle(300);
        chk("glitch_rdy", {31'b0, rdy}, 32'd0);
        chk("glitch_data", {24'b0, rx_data}, 32'h5A);
        send_frame(8'hC3, 1'b1);
        idle(10);

        // clr_rdy pulse 50 clocks after rdy rises
        fork
            send_frame(8'h96, 1'b1);
            begin
                idle(LAT + 50);
                chk("clr_pre_rdy", {31'b0, rdy}, 32'd1);
                clr_rdy = 1'b1;
                idle(1);
                clr_rdy = 1'b0;
                chk("clr_rdy", {31'b0, rdy}, 32'd0);
                chk("clr_data", {24'b0, rx_data}, 32'h96);
            end
        join
        idle(10);

        // clr_rdy in the very cycle rdy sets: set wins
        fork
            send_frame(8'h69, 1'b1);
            begin
                idle(LAT - 1);
                clr_rdy = 1'b1;
                idle(1);
                clr_rdy = 1'b0;
                chk("clr_vs_set", {31'b0, rdy}, 32'd1);
            end
        join
        idle(10);

        // reset during data bit 4 aborts the frame with nothing reported
        ab = 8'h3A;
        RX = 1'b0;
        idle(BAUD);
        for (int i = 0; i < 4; i++) begin
            RX = ab[i];
            idle(BAUD);
        end
        RX = ab[4];
        idle(200);
        rst = 1'b1;
        RX = 1'b1;
        idle(1);
        chk("midrst_rdy", {31'b0, rdy}, 32'd0);
        chk("midrst_data", {24'b0, rx_data}, 32'd0);
        chk("midrst_ferr", {31'b0, framing_err}, 32'd0);
        rst = 1'b0;
        idle(LAT);
        chk("midrst_quiet", {31'b0, rdy}, 32'd0);
        send_frame(8'h81, 1'b1);
        idle(10);

        // bad stop bit
        send_frame(8'h55, 1'b0);
        idle(20);

        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            gap = $urandom_range(0, 40);
            if (gap > 0) idle(gap);
            send_frame(d, 1'b1);
        end

        for (int t = 0; t < 5000 && sb.size() > 0; t++)
            idle(1);
        chk("scoreboard_empty", sb.size(), 32'd0);
        idle(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
